// File: rtl/card_shoe_dealer_if.sv
// Draw/shuffle handshake between the card shoe and its clients.
// The slave side is the dealer; the master side is the game logic that requests cards.
interface card_shoe_dealer_if;
    logic       i_drawReq;
    logic       i_shuffleReq;
    logic       i_entropy;
    logic [5:0] o_card;
    logic       o_cardValid;
    logic       o_ready;
    logic [5:0] o_cardsRemaining;
    logic       o_shuffling;

    modport slave (
        input  i_drawReq,
        input  i_shuffleReq,
        input  i_entropy,
        output o_card,
        output o_cardValid,
        output o_ready,
        output o_cardsRemaining,
        output o_shuffling
    );

    modport master (
        output i_drawReq,
        output i_shuffleReq,
        output i_entropy,
        input  o_card,
        input  o_cardValid,
        input  o_ready,
        input  o_cardsRemaining,
        input  o_shuffling
    );
endinterface

// File: rtl/card_shoe_dealer.sv
// 52-card shoe: fills the deck, shuffles it with LFSR-driven Fisher-Yates passes,
// then deals one card per granted draw request without replacement.
module card_shoe_dealer #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          SHUFFLE_PASSES = 1,
    parameter bit          AUTO_RESHUFFLE = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    card_shoe_dealer_if.slave         bus
);

    typedef enum logic [1:0] {
        S_FILL,
        S_SHUFFLE,
        S_READY,
        S_EMPTY
    } state_t;

    localparam logic [5:0] LAST_IDX  = 6'd51;
    localparam logic [5:0] DECK_SIZE = 6'd52;
    localparam logic [1:0] LAST_PASS = 2'(SHUFFLE_PASSES - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  fill_idx_q, fill_idx_d;
    logic [5:0]  k_q, k_d;
    logic [1:0]  pass_q, pass_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  remaining_q, remaining_d;
    logic [5:0]  card_q, card_d;
    logic        card_valid_q, card_valid_d;
    logic [5:0]  deck_q [52];
    logic [5:0]  deck_d [52];

    logic [15:0] lfsr_shifted;
    logic [5:0]  rnd;
    logic        swap_ok;

    function automatic logic [5:0] card_code(input logic [5:0] idx);
        logic [1:0] suit;
        logic [5:0] off;
        off  = idx;
        suit = 2'd0;
        if (idx < 6'd13) begin
            suit = 2'd0;
            off  = idx + 6'd1;
        end else if (idx < 6'd26) begin
            suit = 2'd1;
            off  = idx - 6'd12;
        end else if (idx < 6'd39) begin
            suit = 2'd2;
            off  = idx - 6'd25;
        end else begin
            suit = 2'd3;
            off  = idx - 6'd38;
        end
        return {suit, off[3:0]};
    endfunction

    // Smallest all-ones mask covering k, so rejection keeps acceptance at or above one half.
    function automatic logic [5:0] k_mask(input logic [5:0] k);
        logic [5:0] m;
        if (k >= 6'd32)      m = 6'd63;
        else if (k >= 6'd16) m = 6'd31;
        else if (k >= 6'd8)  m = 6'd15;
        else if (k >= 6'd4)  m = 6'd7;
        else if (k >= 6'd2)  m = 6'd3;
        else                 m = 6'd1;
        return m;
    endfunction

    always_comb begin
        lfsr_shifted    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        lfsr_shifted[0] = lfsr_shifted[0] ^ bus.i_entropy;
        lfsr_d          = (lfsr_shifted == 16'h0000) ? LFSR_SEED : lfsr_shifted;
    end

    assign rnd     = lfsr_q[5:0] & k_mask(k_q);
    assign swap_ok = (rnd <= k_q);

    always_comb begin
        state_d      = state_q;
        fill_idx_d   = fill_idx_q;
        k_d          = k_q;
        pass_d       = pass_q;
        ptr_d        = ptr_q;
        remaining_d  = remaining_q;
        card_d       = card_q;
        card_valid_d = 1'b0;
        deck_d       = deck_q;

        case (state_q)
            S_FILL: begin
                deck_d[fill_idx_q] = card_code(fill_idx_q);
                remaining_d        = 6'd0;
                if (fill_idx_q == LAST_IDX) begin
                    fill_idx_d = 6'd0;
                    k_d        = LAST_IDX;
                    pass_d     = 2'd0;
                    state_d    = S_SHUFFLE;
                end else begin
                    fill_idx_d = fill_idx_q + 6'd1;
                end
            end

            S_SHUFFLE: begin
                if (swap_ok) begin
                    deck_d[k_q] = deck_q[rnd];
                    deck_d[rnd] = deck_q[k_q];
                    if (k_q == 6'd1) begin
                        if (pass_q != LAST_PASS) begin
                            pass_d = pass_q + 2'd1;
                            k_d    = LAST_IDX;
                        end else begin
                            state_d     = S_READY;
                            ptr_d       = 6'd0;
                            remaining_d = DECK_SIZE;
                        end
                    end else begin
                        k_d = k_q - 6'd1;
                    end
                end
            end

            // A shuffle request outranks a draw in the same cycle.
            S_READY: begin
                if (bus.i_shuffleReq) begin
                    state_d     = S_FILL;
                    fill_idx_d  = 6'd0;
                    remaining_d = 6'd0;
                end else if (remaining_q == 6'd0) begin
                    state_d    = AUTO_RESHUFFLE ? S_FILL : S_EMPTY;
                    fill_idx_d = 6'd0;
                end else if (bus.i_drawReq) begin
                    card_d       = deck_q[ptr_q];
                    card_valid_d = 1'b1;
                    ptr_d        = ptr_q + 6'd1;
                    remaining_d  = remaining_q - 6'd1;
                end
            end

            S_EMPTY: begin
                if (bus.i_shuffleReq) begin
                    state_d    = S_FILL;
                    fill_idx_d = 6'd0;
                end
            end

            default: begin
                state_d    = S_FILL;
                fill_idx_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_FILL;
            lfsr_q       <= LFSR_SEED;
            fill_idx_q   <= 6'd0;
            k_q          <= LAST_IDX;
            pass_q       <= 2'd0;
            ptr_q        <= 6'd0;
            remaining_q  <= 6'd0;
            card_q       <= 6'd0;
            card_valid_q <= 1'b0;
            for (int i = 0; i < 52; i++) begin
                deck_q[i] <= 6'd0;
            end
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            fill_idx_q   <= fill_idx_d;
            k_q          <= k_d;
            pass_q       <= pass_d;
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            deck_q       <= deck_d;
        end
    end

    assign bus.o_card           = card_q;
    assign bus.o_cardValid      = card_valid_q;
    assign bus.o_cardsRemaining = remaining_q;
    assign bus.o_ready          = (state_q == S_READY) && (remaining_q != 6'd0);
    assign bus.o_shuffling      = (state_q == S_FILL) || (state_q == S_SHUFFLE);

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Bench for card_shoe_dealer: compares dealt cards and ready timing against a
// Fisher-Yates reference model fed by its own LFSR arithmetic.
`timescale 1ns/1ps
module tb_card_shoe_dealer;

    localparam int SEED   = 'hACE1;
    localparam int PASSES = 1;

    logic i_clk = 1'b0;
    logic i_reset;

    card_shoe_dealer_if bus_if();

    card_shoe_dealer #(
        .LFSR_SEED      (16'hACE1),
        .SHUFFLE_PASSES (PASSES),
        .AUTO_RESHUFFLE (1'b1)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_if)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_deck [52];
    int saved_deck [52];
    int model_ready;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int lfsr_step(input int v, input int e);
        int n;
        n = (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
        n = n ^ e;
        if (n == 0) n = SEED;
        return n;
    endfunction

    // Fill takes cycles 0..51; shuffle draws one LFSR value per cycle from cycle 52.
    task automatic computeModel(input int ent_cycle);
        int l, j, k, pass, bound, r, t;
        l = SEED;
        for (int i = 0; i < 52; i++) model_deck[i] = ((i / 13) << 4) | ((i % 13) + 1);
        for (j = 0; j < 52; j++) l = lfsr_step(l, (j == ent_cycle) ? 1 : 0);
        k = 51;
        pass = 0;
        j = 52;
        while (j < 20000) begin
            bound = 2;
            while (bound <= k) bound = bound * 2;
            r = l % bound;
            if (r <= k) begin
                t = model_deck[k];
                model_deck[k] = model_deck[r];
                model_deck[r] = t;
                k--;
            end
            l = lfsr_step(l, (j == ent_cycle) ? 1 : 0);
            j++;
            if (k == 0) begin
                pass++;
                if (pass == PASSES) break;
                k = 51;
            end
        end
        model_ready = j;
    endtask

    task automatic tick();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic applyStimulus(input bit draw, input bit shuf, input bit ent);
        bus_if.i_drawReq    = draw;
        bus_if.i_shuffleReq = shuf;
        bus_if.i_entropy    = ent;
    endtask

    task automatic resetDut();
        i_reset = 1'b1;
        applyStimulus(0, 0, 0);
        #12;
        @(negedge i_clk);
        i_reset = 1'b0;
        cyc = 0;
    endtask

    task automatic waitReady(input int ent_cycle, input int budget, output int strobes, output int ready_at);
        int start;
        start    = cyc;
        strobes  = 0;
        ready_at = -1;
        while (cyc - start < budget) begin
            bus_if.i_entropy = (cyc == ent_cycle);
            if (bus_if.o_ready) begin
                ready_at = cyc;
                break;
            end
            if (bus_if.o_cardValid) strobes++;
            tick();
        end
        bus_if.i_entropy = 1'b0;
    endtask

    task automatic drawAllBackToBack(input string tag);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 52; i++) begin
            tick();
            if (i == 51) applyStimulus(0, 0, 0);
            checkOutput({tag, "_valid"}, bus_if.o_cardValid, 1);
            checkOutput({tag, "_card"}, bus_if.o_card, model_deck[i]);
        end
        checkOutput({tag, "_ready_low"}, bus_if.o_ready, 0);
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s, r, cov, g, differ, guard;
        bit req, exp_valid;
        logic [63:0] seen;

        // Scenario 1: reset state and the first shuffle
        resetDut();
        checkOutput("rst_shuffling", bus_if.o_shuffling, 1);
        checkOutput("rst_ready", bus_if.o_ready, 0);
        checkOutput("rst_remaining", bus_if.o_cardsRemaining, 0);
        checkOutput("rst_valid", bus_if.o_cardValid, 0);
        checkOutput("rst_card", bus_if.o_card, 0);
        computeModel(-1);
        for (int i = 0; i < 52; i++) saved_deck[i] = model_deck[i];
        waitReady(-1, 5000, s, r);
        checkOutput("ready_cycle", r, model_ready);
        checkOutput("ready_ge_103", (r >= 103) ? 1 : 0, 1);
        checkOutput("strobes_in_shuffle", s, 0);
        checkOutput("full_remaining", bus_if.o_cardsRemaining, 52);

        // Scenario 2: 52 spaced single-cycle draws
        seen = '0;
        for (int i = 0; i < 52; i++) begin
            applyStimulus(1, 0, 0);
            tick();
            applyStimulus(0, 0, 0);
            checkOutput("draw_valid", bus_if.o_cardValid, 1);
            checkOutput("draw_card", bus_if.o_card, model_deck[i]);
            checkOutput("draw_remaining", bus_if.o_cardsRemaining, 51 - i);
            seen[bus_if.o_card] = 1'b1;
            if (i < 51) begin
                tick();
                checkOutput("valid_one_cycle", bus_if.o_cardValid, 0);
                tick();
            end
        end
        checkOutput("last_ready_low", bus_if.o_ready, 0);
        cov = 0;
        for (int su = 0; su < 4; su++)
            for (int rk = 1; rk <= 13; rk++)
                if (seen[su * 16 + rk]) cov++;
        checkOutput("coverage", cov, 52);

        // Scenario 3: request held through the automatic reshuffle
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("draw_when_empty", bus_if.o_cardValid, 0);
        checkOutput("auto_shuffling", bus_if.o_shuffling, 1);
        waitReady(-1, 5000, s, r);
        checkOutput("reshuffle_ready", (r >= 0) ? 1 : 0, 1);
        checkOutput("reshuffle_strobes", s, 0);
        checkOutput("reshuffle_remaining", bus_if.o_cardsRemaining, 52);
        tick();
        checkOutput("first_after_ready", bus_if.o_cardValid, 1);
        checkOutput("first_after_ready_rem", bus_if.o_cardsRemaining, 51);
        checkOutput("rank_legal", (((bus_if.o_card & 15) >= 1) && ((bus_if.o_card & 15) <= 13)) ? 1 : 0, 1);

        // Scenario 4: shuffle request collides with a draw at remaining=40
        for (int i = 0; i < 11; i++) tick();
        checkOutput("rem_40", bus_if.o_cardsRemaining, 40);
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("collide_no_card", bus_if.o_cardValid, 0);
        checkOutput("collide_rem", bus_if.o_cardsRemaining, 0);
        checkOutput("collide_shuffling", bus_if.o_shuffling, 1);
        waitReady(-1, 5000, s, r);
        checkOutput("collide_ready", (r >= 0) ? 1 : 0, 1);
        checkOutput("collide_full", bus_if.o_cardsRemaining, 52);

        // Scenario 5a: same seed, random draw pattern, same sequence
        resetDut();
        computeModel(-1);
        waitReady(-1, 5000, s, r);
        checkOutput("runB_ready_cycle", r, model_ready);
        g = 0;
        guard = 0;
        while (g < 52 && guard < 1000) begin
            req = 1'($urandom_range(0, 1));
            applyStimulus(req, 0, 0);
            exp_valid = req && (g < 52);
            if (exp_valid) g++;
            tick();
            checkOutput("rand_valid", bus_if.o_cardValid, exp_valid);
            if (exp_valid) checkOutput("rand_card", bus_if.o_card, model_deck[g - 1]);
            checkOutput("rand_rem", bus_if.o_cardsRemaining, 52 - g);
            guard++;
        end
        applyStimulus(0, 0, 0);
        checkOutput("rand_all_dealt", g, 52);

        // Scenario 5b: one entropy pulse at cycle 10 changes the deck
        resetDut();
        computeModel(10);
        waitReady(10, 5000, s, r);
        checkOutput("runC_ready_cycle", r, model_ready);
        differ = 0;
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 52; i++) begin
            tick();
            if (i == 51) applyStimulus(0, 0, 0);
            checkOutput("runC_card", bus_if.o_card, model_deck[i]);
            if (bus_if.o_card != saved_deck[i]) differ++;
        end
        checkOutput("entropy_differs", (differ != 0) ? 1 : 0, 1);

        // Scenario 6: three-cycle burst, then reset in the middle of a reshuffle
        resetDut();
        computeModel(-1);
        waitReady(-1, 5000, s, r);
        checkOutput("runD_ready_cycle", r, model_ready);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) applyStimulus(0, 0, 0);
            checkOutput("burst_valid", bus_if.o_cardValid, 1);
            checkOutput("burst_card", bus_if.o_card, model_deck[i]);
        end
        tick();
        checkOutput("burst_end", bus_if.o_cardValid, 0);
        checkOutput("burst_rem", bus_if.o_cardsRemaining, 49);
        applyStimulus(1, 0, 0);
        for (int i = 3; i < 52; i++) begin
            tick();
            if (i == 51) applyStimulus(0, 0, 0);
            checkOutput("rest_card", bus_if.o_card, model_deck[i]);
        end
        for (int i = 0; i < 70; i++) tick();
        checkOutput("pre_reset_card", (bus_if.o_card != 0) ? 1 : 0, 1);
        i_reset = 1'b1;
        #1;
        checkOutput("async_card", bus_if.o_card, 0);
        checkOutput("async_valid", bus_if.o_cardValid, 0);
        checkOutput("async_rem", bus_if.o_cardsRemaining, 0);
        checkOutput("async_ready", bus_if.o_ready, 0);
        checkOutput("async_shuffling", bus_if.o_shuffling, 1);
        @(negedge i_clk);
        i_reset = 1'b0;
        cyc = 0;
        waitReady(-1, 5000, s, r);
        checkOutput("post_reset_ready_cycle", r, model_ready);
        drawAllBackToBack("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
